// File: rtl/sweep_compare_ctrl.sv
// ---------------------------------------------------------------------------
// sweep_compare_ctrl
//
// Exhaustive self-check sequencer for a WIDTH-input boolean datapath. Every
// code 0 .. 2^WIDTH-1 is driven on x to two implementations (A: mux-based,
// B: gate-based). Each code is held HOLD_CYCLES cycles to settle, then both
// outputs are compared in a single COMPARE cycle. The block reports pass/fail,
// how many codes mismatched and the first failing code.
//
// Parameters:
//   WIDTH        width of the code x (sweep covers 2^WIDTH codes)
//   HOLD_CYCLES  settle cycles per code before sampling (>= 1)
//
// Optional build macro:
//   SWEEP_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep
//                          with x held at the failing code.
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous reset, active-high
//   start             level-sampled sweep request (ignored while busy)
//   x                 code driven to both implementations
//   f_a, f_b          outputs of implementation A and B
//   busy              high while settling or comparing
//   done              high once the sweep has finished, until the next start
//   pass              high in done when no mismatch was seen
//   mismatch_count    number of codes where f_a != f_b
//   first_fail_valid  a mismatch has been recorded in this sweep
//   first_fail_vec    code of the first mismatch (0 when none)
// ---------------------------------------------------------------------------
module sweep_compare_ctrl #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] x,
    input  logic             f_a,
    input  logic             f_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   mismatch_count,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    // A one-cycle hold still needs a one-bit counter.
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] X_LAST    = '1;
    localparam logic [WIDTH-1:0] X_ONE     = WIDTH'(1);
    localparam logic [WIDTH:0]   CNT_ONE   = (WIDTH + 1)'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_x;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [WIDTH:0]     r_mismatch_count;
    logic               r_first_fail_valid;
    logic [WIDTH-1:0]   r_first_fail_vec;

    logic               w_mismatch;
    logic               w_hold_end;
    logic               w_last_code;
    logic               w_stop;
    logic               w_launch;

    assign w_mismatch  = f_a ^ f_b;
    assign w_hold_end  = (r_hold_cnt == HOLD_LAST);
    assign w_last_code = (r_x == X_LAST);
    // A new sweep may only be launched from an idle or finished sequencer.
    assign w_launch    = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef SWEEP_STOP_ON_FAIL_EN
    assign w_stop = w_last_code || w_mismatch;
`else
    assign w_stop = w_last_code;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment first keeps every path driven, so no
    // latch is inferred when a branch leaves the state unchanged.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)      w_next_state = S_SETTLE;
            S_SETTLE:       if (w_hold_end) w_next_state = S_COMPARE;
            S_COMPARE:      w_next_state = w_stop ? S_DONE : S_SETTLE;
            default:        w_next_state = S_IDLE;
        endcase
    end

    // Sweep datapath: code, settle counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x                <= '0;
            r_hold_cnt         <= '0;
            r_mismatch_count   <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_vec   <= '0;
        end else if (w_launch) begin
            r_x                <= '0;
            r_hold_cnt         <= '0;
            r_mismatch_count   <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_vec   <= '0;
        end else begin
            case (r_state)
                S_SETTLE: begin
                    r_hold_cnt <= w_hold_end ? '0 : r_hold_cnt + HOLD_ONE;
                end
                S_COMPARE: begin
                    if (w_mismatch) begin
                        r_mismatch_count <= r_mismatch_count + CNT_ONE;
                        if (!r_first_fail_valid) begin
                            r_first_fail_valid <= 1'b1;
                            r_first_fail_vec   <= r_x;
                        end
                    end
                    // On the final (or stopping) compare x is left on the
                    // last code driven.
                    if (!w_stop) begin
                        r_x        <= r_x + X_ONE;
                        r_hold_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign x                = r_x;
    assign busy             = (r_state == S_SETTLE) || (r_state == S_COMPARE);
    assign done             = (r_state == S_DONE);
    assign pass             = done && (r_mismatch_count == '0);
    assign mismatch_count   = r_mismatch_count;
    assign first_fail_valid = r_first_fail_valid;
    assign first_fail_vec   = r_first_fail_vec;

endmodule

// File: tb/tb_sweep_compare_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sweep_compare_ctrl
//
// Drives sweep_compare_ctrl with a modelled datapath: f_a = x[0]^x[3] and
// f_b = f_a inverted on every code whose bit is set in a 16-bit fault mask.
// Directed sweeps come from a table of constant expectations; randomized
// masks are checked against a reference model that derives the results from
// the mask alone (popcount, lowest set code, sweep length).
// ---------------------------------------------------------------------------
module tb_sweep_compare_ctrl;

    localparam int WIDTH    = 4;
    localparam int HOLD     = 4;
    localparam int NCODES   = 1 << WIDTH;
    localparam int PER_CODE = HOLD + 1;

`ifdef SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] x;
    logic             f_a;
    logic             f_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH:0]   mismatch_count;
    logic             first_fail_valid;
    logic [WIDTH-1:0] first_fail_vec;
    logic [15:0]      mask = '0;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign f_a = x[0] ^ x[3];
    assign f_b = f_a ^ mask[x];

    sweep_compare_ctrl #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .x                (x),
        .f_a              (f_a),
        .f_b              (f_b),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .mismatch_count   (mismatch_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec)
    );

    typedef struct {
        string       name;
        logic [15:0] mask;
        bit          hold_start;
        bit          exp_pass;
        int          exp_cnt;
        bit          exp_ffv;
        int          exp_ffvec;
        int          exp_x;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: results follow directly from the fault mask.
    function automatic vec_t model(input logic [15:0] m);
        vec_t v;
        int   first = -1;
        for (int i = 0; i < NCODES; i++)
            if (m[i] && first < 0) first = i;
        v.name       = "random";
        v.mask       = m;
        v.hold_start = 1'b0;
        v.exp_ffv    = (first >= 0);
        v.exp_ffvec  = (first >= 0) ? first : 0;
        v.exp_pass   = (first < 0);
        if (STOP_EN && first >= 0) begin
            v.exp_cnt = 1;
            v.exp_x   = first;
            v.exp_lat = (first + 1) * PER_CODE;
        end else begin
            v.exp_cnt = $countones(m);
            v.exp_x   = NCODES - 1;
            v.exp_lat = NCODES * PER_CODE;
        end
        return v;
    endfunction

    task automatic check_all_zero(input string name);
        check({name, " x"},     32'(x), 0);
        check({name, " flags"}, {28'd0, busy, done, pass, first_fail_valid}, 0);
        check({name, " cnt"},   32'(mismatch_count), 0);
        check({name, " ffvec"}, 32'(first_fail_vec), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full sweep; samples every cycle on the falling edge. k counts
    // rising edges after the start edge (k=0 is the start edge itself).
    task automatic run_sweep(input vec_t v);
        mask = v.mask;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k <= v.exp_lat; k++) begin
            @(negedge clk);
            if (!v.hold_start) start = 1'b0;
            if (k < v.exp_lat) begin
                check({v.name, " x step"}, 32'(x), 32'(k / PER_CODE));
                check({v.name, " busy/done/pass"}, {29'd0, busy, done, pass}, 32'b100);
            end else begin
                check({v.name, " done latency"}, {30'd0, busy, done}, 32'b01);
                check({v.name, " pass"}, 32'(pass), 32'(v.exp_pass));
                check({v.name, " mismatch_count"}, 32'(mismatch_count), 32'(v.exp_cnt));
                check({v.name, " ff_valid"}, 32'(first_fail_valid), 32'(v.exp_ffv));
                check({v.name, " ff_vec"}, 32'(first_fail_vec), 32'(v.exp_ffvec));
                check({v.name, " final x"}, 32'(x), 32'(v.exp_x));
            end
        end
        if (v.hold_start) begin
            // Start still high: the next edge relaunches from code 0.
            @(negedge clk);
            check({v.name, " relaunch"}, {27'd0, busy, done, x}, {27'd0, 1'b1, 1'b0, 4'd0});
            check({v.name, " relaunch cnt"}, 32'(mismatch_count), 0);
            start = 1'b0;
        end else begin
            // Without start the result is held.
            repeat (3) @(negedge clk);
            check({v.name, " done held"}, {29'd0, busy, done, pass}, {29'd0, 1'b0, 1'b1, v.exp_pass});
            check({v.name, " cnt held"}, 32'(mismatch_count), 32'(v.exp_cnt));
        end
    endtask

    vec_t tbl[5];

    initial begin
        // Directed sweeps with hand-derived expectations.
        tbl[0] = '{"clean", 16'h0000, 1'b0, 1'b1, 0, 1'b0, 0, 15, 80};
`ifdef SWEEP_STOP_ON_FAIL_EN
        tbl[1] = '{"fail_at_5", 16'h0020, 1'b0, 1'b0, 1, 1'b1, 5, 5, 30};
        tbl[2] = '{"all_fail", 16'hFFFF, 1'b0, 1'b0, 1, 1'b1, 0, 0, 5};
        tbl[3] = '{"fail_3_9", 16'h0208, 1'b0, 1'b0, 1, 1'b1, 3, 3, 20};
`else
        tbl[1] = '{"fail_at_5", 16'h0020, 1'b0, 1'b0, 1, 1'b1, 5, 15, 80};
        tbl[2] = '{"all_fail", 16'hFFFF, 1'b0, 1'b0, 16, 1'b1, 0, 15, 80};
        tbl[3] = '{"fail_3_9", 16'h0208, 1'b0, 1'b0, 2, 1'b1, 3, 15, 80};
`endif
        tbl[4] = '{"start_held", 16'h0000, 1'b1, 1'b1, 0, 1'b0, 0, 15, 80};

        // Reset state, while asserted and after release.
        repeat (2) @(negedge clk);
        check_all_zero("in reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        for (int i = 0; i < 5; i++) begin
            run_sweep(tbl[i]);
            if (tbl[i].hold_start) do_reset();
        end

        // Mid-sweep reset while x=7 is settling: results vanish at once.
        mask = 16'h0003;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7 * PER_CODE) @(negedge clk);
        check("abort pre x", {30'd0, busy, done}, 32'b10);
        check("abort pre x value", 32'(x), 7);
        #2 rst = 1'b1;
        #1 check_all_zero("async reset");
        @(negedge clk);
        rst = 1'b0;
        run_sweep(tbl[0]);

        // Randomized fault masks against the reference model.
        for (int r = 0; r < 6; r++) begin
            logic [31:0] rnd;
            rnd = $urandom & $urandom & $urandom;
            if (r == 0) rnd = '0;
            run_sweep(model(rnd[15:0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
